// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA display path.
//   - default 640x480@60 Hz timing (25 MHz pixel clock)
//   - frame-buffer geometry, address/data widths
//   - RGB565 field positions within a frame-buffer word
//   - vga_ctl_t: the de/hs/vs bundle carried through the latency pipeline
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_IMG_W = 320;
    localparam int VGA_IMG_H = 240;

    // 320*240 = 76800 words -> 17 address bits
    localparam int ADDR_W = $clog2(VGA_IMG_W * VGA_IMG_H);
    localparam int DATA_W = 16;
    // Both counters fit in 10 bits (max 799 and 524)
    localparam int CNT_W  = 10;

    // RGB565 layout
    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;
    localparam int R_W  = R_HI - R_LO + 1;
    localparam int G_W  = G_HI - G_LO + 1;
    localparam int B_W  = B_HI - B_LO + 1;

    typedef struct packed {
        logic de;
        logic hs_n;
        logic vs_n;
    } vga_ctl_t;

    localparam vga_ctl_t CTL_IDLE = '{de: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port plus VGA output bus of the frame reader.
//   fb_rd_en / fb_rd_addr : read request toward the frame buffer
//   fb_rd_data            : RGB565 word returned RD_LAT clocks later
//   hs / vs               : active-low syncs
//   vga_r / vga_g / vga_b : 5/6/5 colour
//   frame_start           : one-clock pulse at the counter origin
// master = the frame reader, slave = memory/display side.
interface vga_frame_reader_if;
    import vga_pkg::*;

    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_rd_addr;
    logic [DATA_W-1:0] fb_rd_data;
    logic              hs;
    logic              vs;
    logic [R_W-1:0]    vga_r;
    logic [G_W-1:0]    vga_g;
    logic [B_W-1:0]    vga_b;
    logic              frame_start;

    modport master (
        output fb_rd_en, fb_rd_addr, hs, vs, vga_r, vga_g, vga_b, frame_start,
        input  fb_rd_data
    );

    modport slave (
        input  fb_rd_en, fb_rd_addr, hs, vs, vga_r, vga_g, vga_b, frame_start,
        output fb_rd_data
    );

endinterface

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical position counters and undelayed (stage 0) timing.
//   mclk, rst   : pixel clock, asynchronous active-high reset
//   h_cnt/v_cnt : current raster position
//   de0         : inside the visible area
//   hs0/vs0     : active-low syncs for the current position
//   frame_start : registered pulse, high the clock after the origin (0,0)
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             mclk,
    input  logic             rst,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             de0,
    output logic             hs0,
    output logic             vs0,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign de0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs0 = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs0 = !((v_cnt >= VS_START) && (v_cnt < VS_END));

endmodule

// File: rtl/vga_frame_reader.sv
// VGA frame reader: scans a 320x240 RGB565 frame buffer onto a 640x480
// raster with 2x pixel and line replication.
//   mclk, rst : pixel clock, asynchronous active-high reset
//   bus       : frame-buffer read port and VGA outputs (master side)
// A raster position issues its read in the same clock; its sync and colour
// appear on the outputs RD_LAT+1 clocks later, so the de/hs/vs bundle is
// delayed RD_LAT clocks to meet the returning data, then registered once.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int IMG_W    = VGA_IMG_W,
    parameter int RD_LAT   = 2   // 1..4
) (
    input  logic               mclk,
    input  logic               rst,
    vga_frame_reader_if.master bus
);

    localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0]  V_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    // Advance the line base after every second visible line, but not after
    // the last one, so the base never points past the final image row.
    localparam logic [CNT_W-1:0]  V_INC_LIM = CNT_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic              de0;
    logic              hs0;
    logic              vs0;
    logic              frame_start;
    logic              rd_active;
    logic [ADDR_W-1:0] line_base_reg;

    vga_sync_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_sync (
        .mclk        (mclk),
        .rst         (rst),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .de0         (de0),
        .hs0         (hs0),
        .vs0         (vs0),
        .frame_start (frame_start)
    );

    // Incremental row base avoids a v*IMG_W multiplier.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            line_base_reg <= '0;
        end else if (h_cnt == H_LAST) begin
            if (v_cnt == V_LAST)
                line_base_reg <= '0;
            else if (v_cnt[0] && (v_cnt < V_INC_LIM))
                line_base_reg <= line_base_reg + ROW_STEP;
        end
    end

    // Counters sit at the origin during reset, which is a visible position;
    // gating with rst keeps the read port idle while reset is held.
    assign rd_active      = de0 & ~rst;
    assign bus.fb_rd_en   = rd_active;
    assign bus.fb_rd_addr = rd_active ? line_base_reg + ADDR_W'(h_cnt >> 1) : '0;

    vga_ctl_t ctl0;
    vga_ctl_t ctl_pipe [RD_LAT];

    assign ctl0 = '{de: de0, hs_n: hs0, vs_n: vs0};

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_lat
            vga_ctl_t stage_in;
            if (gi == 0) begin : g_first
                assign stage_in = ctl0;
            end else begin : g_rest
                assign stage_in = ctl_pipe[gi-1];
            end
            always_ff @(posedge mclk or posedge rst) begin
                if (rst) ctl_pipe[gi] <= CTL_IDLE;
                else     ctl_pipe[gi] <= stage_in;
            end
        end
    endgenerate

    vga_ctl_t       ctl_d;
    logic           hs_reg;
    logic           vs_reg;
    logic [R_W-1:0] r_reg;
    logic [G_W-1:0] g_reg;
    logic [B_W-1:0] b_reg;

    assign ctl_d = ctl_pipe[RD_LAT-1];

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            hs_reg <= 1'b1;
            vs_reg <= 1'b1;
            r_reg  <= '0;
            g_reg  <= '0;
            b_reg  <= '0;
        end else begin
            hs_reg <= ctl_d.hs_n;
            vs_reg <= ctl_d.vs_n;
            if (ctl_d.de) begin
                r_reg <= bus.fb_rd_data[R_HI:R_LO];
                g_reg <= bus.fb_rd_data[G_HI:G_LO];
                b_reg <= bus.fb_rd_data[B_HI:B_LO];
            end else begin
                r_reg <= '0;
                g_reg <= '0;
                b_reg <= '0;
            end
        end
    end

    assign bus.hs          = hs_reg;
    assign bus.vs          = vs_reg;
    assign bus.vga_r       = r_reg;
    assign bus.vga_g       = g_reg;
    assign bus.vga_b       = b_reg;
    assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader. Horizontal timing is the full 640-pixel line;
// vertical timing is shortened to 14 lines so several whole frames fit in a
// short run. Expected outputs come from raster arithmetic (position = cycle
// count since reset release, row base = (v/2)*IMG_W).
module tb_vga_frame_reader;
    import vga_pkg::*;

    localparam int H_A = 640, H_F = 16, H_S = 96, H_B = 48;
    localparam int V_A = 8,   V_F = 2,  V_S = 2,  V_B = 2;
    localparam int LAT = 2;
    localparam int IW  = 320;
    localparam int HT  = H_A + H_F + H_S + H_B;
    localparam int VT  = V_A + V_F + V_S + V_B;
    localparam int FRAME = HT * VT;

    logic mclk = 1'b0;
    logic rst  = 1'b1;
    always #20 mclk = ~mclk;

    vga_frame_reader_if bus ();

    vga_frame_reader #(
        .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
        .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
        .IMG_W(IW), .RD_LAT(LAT)
    ) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    // Frame-buffer model: mode 0 random contents, 1 constant 0xFFFF,
    // 2 returns the low 16 address bits.
    logic [15:0] mem [76800];
    int          mem_mode;
    logic [15:0] rd_pipe [LAT];

    function automatic logic [15:0] mem_word(input int a);
        logic [31:0] av;
        av = a;
        case (mem_mode)
            0:       return mem[a];
            1:       return 16'hFFFF;
            default: return av[15:0];
        endcase
    endfunction

    always @(posedge mclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) rd_pipe[i] <= '0;
        end else begin
            rd_pipe[0] <= mem_word(int'(bus.fb_rd_addr));
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign bus.fb_rd_data = rd_pipe[LAT-1];

    int checks = 0;
    int errors = 0;
    int cur_k  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_hs"},    32'(bus.hs), 32'd1);
        chk({pfx, "_vs"},    32'(bus.vs), 32'd1);
        chk({pfx, "_rgb"},   32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'd0);
        chk({pfx, "_en"},    32'(bus.fb_rd_en), 32'd0);
        chk({pfx, "_addr"},  32'(bus.fb_rd_addr), 32'd0);
        chk({pfx, "_fs"},    32'(bus.frame_start), 32'd0);
    endtask

    // Edge bookkeeping for sync width/period measurement
    logic prev_hs, prev_vs;
    bit   hs_seen, vs_seen;
    int   hs_fall_k, vs_fall_k;

    task automatic check_cycle(input int k);
        int h, v, ph, pv, exp_addr;
        bit de, pde, exp_hs, exp_vs, exp_fs;
        logic [15:0] exp_rgb;
        cur_k = k;
        h  = k % HT;
        v  = (k / HT) % VT;
        de = (h < H_A) && (v < V_A);
        exp_addr = de ? (v / 2) * IW + h / 2 : 0;
        if (k >= LAT + 1) begin
            ph  = (k - LAT - 1) % HT;
            pv  = ((k - LAT - 1) / HT) % VT;
            pde = (ph < H_A) && (pv < V_A);
            exp_hs  = !((ph >= H_A + H_F) && (ph < H_A + H_F + H_S));
            exp_vs  = !((pv >= V_A + V_F) && (pv < V_A + V_F + V_S));
            exp_rgb = pde ? mem_word((pv / 2) * IW + ph / 2) : 16'h0000;
        end else begin
            exp_hs  = 1'b1;
            exp_vs  = 1'b1;
            exp_rgb = 16'h0000;
        end
        exp_fs = (k >= 1) && (((k - 1) % FRAME) == 0);

        chk("fb_rd_en",    32'(bus.fb_rd_en), 32'(de));
        chk("fb_rd_addr",  32'(bus.fb_rd_addr), 32'(exp_addr));
        chk("hs",          32'(bus.hs), 32'(exp_hs));
        chk("vs",          32'(bus.vs), 32'(exp_vs));
        chk("rgb",         32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(exp_rgb));
        chk("frame_start", 32'(bus.frame_start), 32'(exp_fs));

        if (prev_hs && !bus.hs) begin
            if (!hs_seen) chk("hs_first_fall", 32'(k), 32'(H_A + H_F + LAT + 1));
            else          chk("hs_period", 32'(k - hs_fall_k), 32'(HT));
            hs_seen   = 1'b1;
            hs_fall_k = k;
        end
        if (!prev_hs && bus.hs) chk("hs_low_width", 32'(k - hs_fall_k), 32'(H_S));
        if (prev_vs && !bus.vs) begin
            if (!vs_seen) chk("vs_first_fall", 32'(k), 32'((V_A + V_F) * HT + LAT + 1));
            else          chk("vs_period", 32'(k - vs_fall_k), 32'(FRAME));
            vs_seen   = 1'b1;
            vs_fall_k = k;
        end
        if (!prev_vs && bus.vs) chk("vs_low_width", 32'(k - vs_fall_k), 32'(V_S * HT));
        prev_hs = bus.hs;
        prev_vs = bus.vs;
    endtask

    task automatic release_reset();
        rst       = 1'b0;
        prev_hs   = 1'b1;
        prev_vs   = 1'b1;
        hs_seen   = 1'b0;
        vs_seen   = 1'b0;
        hs_fall_k = 0;
        vs_fall_k = 0;
        #1;
        check_cycle(0);
    endtask

    initial begin
        for (int i = 0; i < 76800; i++) mem[i] = 16'($urandom);
        mem_mode = 2;
        rst = 1'b1;

        repeat (10) @(negedge mclk);
        #1;
        chk_reset("por");

        // Frame 1: address-pattern data, frame 2: constant 0xFFFF,
        // frame 3: random contents; switches happen in vertical blanking.
        release_reset();
        for (int k = 1; k <= 2 * FRAME + 5 * HT + 400; k++) begin
            @(negedge mclk);
            #1;
            check_cycle(k);
            if (k == 2 * HT + 6 + LAT + 1) begin
                chk("pix_6_2_r", 32'(bus.vga_r), 32'h00);
                chk("pix_6_2_g", 32'(bus.vga_g), 32'h0A);
                chk("pix_6_2_b", 32'(bus.vga_b), 32'h03);
            end
            if (k == 8000)         mem_mode = 1;
            if (k == FRAME + 8000) mem_mode = 0;
        end

        // Asynchronous reset in the middle of a visible line
        #1;
        rst = 1'b1;
        #1;
        chk_reset("mid_rst_async");
        mem_mode = 2;
        repeat (5) @(negedge mclk);
        #1;
        chk_reset("mid_rst_hold");

        release_reset();
        for (int k = 1; k <= FRAME + 800; k++) begin
            @(negedge mclk);
            #1;
            check_cycle(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Display-side stage downstream of the camera frame buffer in the OV7670→VGA path.
- Generates 640x480@60 Hz VGA timing on the 25 MHz pixel clock.
- Fetches RGB565 pixels from a 320x240 frame buffer, with 2x pixel/line replication.
- Drives hs/vs and the 5/6/5 colour buses with sync and data aligned for the memory read latency.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- IMG_W, 320, frame-buffer width (pixels)
- IMG_H, 240, frame-buffer height (lines)
- RD_LAT, 2, frame-buffer read latency in clocks (1..4)

Ports:
- mclk  in  1  25 MHz pixel clock; only clock
- rst  in  1  asynchronous, active-high reset
- fb_rd_en  out  1  frame-buffer read enable
- fb_rd_addr  out  17  frame-buffer word address (0..76799)
- fb_rd_data  in  16  RGB565 data, valid RD_LAT clocks after fb_rd_en
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- vga_r  out  5  red
- vga_g  out  6  green
- vga_b  out  5  blue
- frame_start  out  1  one-clock pulse at counter origin (0,0)

Behaviour:
- Interface: one clock, mclk; reset rst is asynchronous and active-high.
- Reset values:
  - h_cnt=0, v_cnt=0, line_base=0
  - fb_rd_en=0, fb_rd_addr=0
  - hs=1, vs=1
  - vga_r/g/b=0, frame_start=0
  - all delay pipelines cleared to inactive (de=0, hs=1, vs=1)
- Counters:
  - h_cnt counts 0..799 and wraps.
  - v_cnt increments when h_cnt wraps; counts 0..524 and wraps.
  - Totals are derived from the parameters.
- Active region: de0 = (h_cnt < 640) && (v_cnt < 480).
- Sync, stage 0:
  - hs0 low for h_cnt in [656,752).
  - vs0 low for v_cnt in [490,492).
- Address generation:
  - fb_rd_en = de0 (combinational from counters).
  - fb_rd_addr = line_base + (h_cnt>>1) when de0, else 0.
  - line_base increments by IMG_W at end of line (h_cnt==799) only when v_cnt is odd and v_cnt < 479.
  - line_base resets to 0 at frame wrap (v_cnt==524, h_cnt==799).
  - No multiplier. Width 17 bits; never exceeds 76799.
- Alignment:
  - de0/hs0/vs0 enter a shift pipeline of depth RD_LAT.
  - Output registers then sample the delayed signals.
  - Counter position (h,v) therefore appears on hs/vs/rgb exactly RD_LAT+1 clocks later.
- Colour output, registered:
  - If delayed de=1: vga_r=fb_rd_data[15:11], vga_g=[10:5], vga_b=[4:0].
  - Otherwise all zero, regardless of fb_rd_data.
- frame_start: registered pulse, high for one clock when counters are at (0,0). Not delayed.
- Reset mid-frame: all state returns to reset values immediately. After release, timing restarts at (0,0), so the first hs falling edge comes 656+RD_LAT+1 clocks later.
- No back-pressure: the frame buffer must answer every read; there is no stall input.

Decomposition:
- Shared package vga_pkg:
  - 640x480 timing constants
  - RGB565 field bit positions
  - address width constant (17)
- Natural sub-module vga_sync_counter:
  - h/v counters, de0, hs0, vs0, frame_start
- vga_frame_reader adds:
  - line_base/address logic
  - latency pipeline
  - colour output registers

Test Plan:
- Reset: hold rst 10 clocks → hs=vs=1, rgb=0, fb_rd_en=0. After release, first fb_rd_en=1 at clock 0 with addr=0, and frame_start pulses once.
- Timing (RD_LAT=2): measure hs → low for 96 clocks, period 800. vs → low for 1600 clocks, period 420000. First hs fall 659 clocks after reset release.
- Address sequence: line 0 → 0,0,1,1,…,319,319. Line 1 repeats the same. Line 2 starts at 320. Line 479 ends at 76799. No reads during blanking.
- Data path: memory model returns addr[15:0] with latency 2. Pixel at (h=6,v=2) → output 0x0143 split as r=0x00, g=0x0A, b=0x03, sampled 3 clocks after the counter passes it.
- Blanking gating: model drives 0xFFFF constantly → rgb=0 whenever delayed de=0, i.e. in all porch/sync periods.
- Mid-frame reset: assert rst at v_cnt=300, h_cnt=400 → outputs go to reset values asynchronously. After release, full-frame timing and address 0 restart cleanly.
